counter_seq_ctrl: RTL
=====================

// Module: counter_seq_ctrl
// PURPOSE
//  Command sequencer for the WIDTH-bit up/down counter; drives its enb, load and data_in.
//  Accepts LOAD / RUN_TO / RUN_CYC / STOP over a valid/ready interface.
//  Reports completion (done) and failures (err: abort or timeout).
//  Lets upper logic use the counter as a bounded, self-stopping resource.
// PARAMETERS
//  WIDTH    4                  counter / argument width; must match the counter's WIDTH
//  TMO_CYC  2**(WIDTH+1)       max enabled cycles a RUN_TO may take before err
// PORTS
//  clk        in   1      single clock, rising edge
//  asyn_rstn  in   1      asynchronous, active-low reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      controller can accept; command transfers on valid&&ready
//  cmd_op     in   2      00 STOP, 01 LOAD, 10 RUN_TO, 11 RUN_CYC
//  cmd_arg    in   WIDTH  LOAD value / RUN_TO target / RUN_CYC cycle count
//  abort      in   1      terminate RUN_TO or RUN_CYC
//  cnt_enb    out  1      to counter enb
//  cnt_load   out  1      to counter load; counter gives load priority over enb
//  cnt_data   out  WIDTH  to counter data_in
//  cnt_count  in   WIDTH  from counter count
//  busy       out  1      state != IDLE
//  done       out  1      1-cycle pulse: command finished
//  err        out  1      valid only with done: 1 = aborted or timed out
// BEHAVIOUR
//  Reset (async): state=IDLE. Outputs: cnt_enb=0, cnt_load=0, cnt_data=0, busy=0, done=0, err=0.
//    cmd_ready=1, since it decodes IDLE. Reset mid-command clears everything immediately.
//    The counter shares asyn_rstn.
//  States: IDLE -> LOAD | RUN | DONE;  LOAD -> DONE;  RUN -> DONE;  DONE -> IDLE.
//  cmd_ready=1 only in IDLE. Command fields are registered at accept (edge k).
//    Inputs are ignored in every other state.
//  No combinational path from cmd_* to any output.
//  STOP: IDLE->DONE. cnt_enb stays 0. done (err=0) in cycle k+1.
//  LOAD: cycle k+1: cnt_load=1, cnt_data=arg, cnt_enb=0, exactly one cycle.
//    Cycle k+2: done, err=0. cnt_count==arg from k+2.
//  RUN_TO: in RUN, cnt_enb = (cnt_count != target) && !abort && !timeout.
//    Match (cnt_count==target) -> DONE, err=0. Counter holds at target.
//    Target already equal at entry: zero enabled cycles, done in k+2.
//  RUN_CYC: cnt_enb=1 for exactly arg cycles, then DONE with err=0.
//    arg=0: IDLE->DONE directly, done in k+1, no enable.
//  Timeout: RUN_TO enabled-cycle count reaching TMO_CYC -> cnt_enb=0 that cycle, DONE with err=1.
//    TMO_CYC >= 2*2**WIDTH covers the counter's full up/down bounce.
//  abort in RUN: cnt_enb=0 in the same cycle, DONE with err=1.
//    abort outside RUN is ignored.
//  Simultaneous events, in priority order:
//    - RUN_TO: match > abort > timeout. Match is err=0.
//    - RUN_CYC: final cycle completing together with abort -> err=0; that cycle still enables.
//  DONE: done=1 for one cycle, cmd_ready=0, busy=1. Next cycle IDLE.
//    Back-to-back commands are therefore 1 cycle apart at minimum.
//  cnt_data is 0 except during LOAD. cnt_load and cnt_enb are never both 1.
// STRUCTURE
//  counter_ctrl_pkg:
//    - op_e enum {OP_STOP, OP_LOAD, OP_RUN_TO, OP_RUN_CYC}
//    - state_e enum {S_IDLE, S_LOAD, S_RUN, S_DONE}
//    - function tmo_cyc(width)
//  Sub-module ctrl_timer: loadable down-counter with zero flag.
//    Width is $clog2(TMO_CYC+1).
//    Loaded with arg for RUN_CYC or TMO_CYC for RUN_TO; decrements on cnt_enb.
//  Top: FSM, argument registers, target comparator.
// TESTING (WIDTH=4, TMO_CYC=32; bench instantiates the real counter)
//  1. Release reset at 125ps, LOAD 0x9 -> cnt_load 1 cycle with cnt_data=9; done, err=0; count=0x9.
//  2. RUN_TO 0x3 from 0x9 -> enb until count==3; done, err=0; count stays 3.
//     Enabled cycles <= 32.
//  3. RUN_TO 0x3 while count==3 -> no cnt_enb cycle; done 2 cycles after accept.
//     RUN_CYC 0 -> done 1 cycle after accept.
//  4. RUN_CYC 5 -> cnt_enb high exactly 5 cycles; count moves 5 steps; done, err=0.
//     cmd_valid held high -> next command accepted only in IDLE.
//  5. abort 4 cycles into RUN_TO -> cnt_enb low the same cycle; done, err=1; count frozen.
//     abort coincident with match -> err=0.
//  6. Stalled counter (enb tied inactive), RUN_TO 0xF -> done, err=1 after 32 cycles.
//     asyn_rstn low mid-RUN -> all outputs 0 immediately, cmd_ready=1.

Source files
------------

// File: rtl/counter_seq_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : counter_seq_ctrl_pkg                                       |
// | Shared command/state encodings and sizing helpers for the counter    |
// | command sequencer.                                                   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package counter_seq_ctrl_pkg;

   // Command opcodes as carried on cmd_op
   typedef enum logic [1:0] {
      OP_STOP    = 2'b00,
      OP_LOAD    = 2'b01,
      OP_RUN_TO  = 2'b10,
      OP_RUN_CYC = 2'b11
   } op_e;

   // Sequencer states
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_LOAD = 2'b01,
      S_RUN  = 2'b10,
      S_DONE = 2'b11
   } state_e;

   localparam int DEF_WIDTH = 4;

   // Default RUN_TO budget: two full sweeps of the counter, enough for the
   // worst case where the counter first has to bounce off an end stop.
   function automatic int tmo_cyc(input int width);
      return 2 ** (width + 1);
   endfunction

   // Width of a down-counter that must hold the value tmo itself
   function automatic int tmr_width(input int tmo);
      return $clog2(tmo + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/counter_seq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : counter_seq_ctrl_if                                      |
// | Command valid/ready channel plus abort and status back to the        |
// | issuing logic.                                                       |
// | Rev       : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
interface counter_seq_ctrl_if
   import counter_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);

   logic             cmd_valid;
   logic             cmd_ready;
   op_e              cmd_op;
   logic [WIDTH-1:0] cmd_arg;
   logic             abort;
   logic             busy;
   logic             done;
   logic             err;

   // Issuer side
   modport master (
      output cmd_valid, cmd_op, cmd_arg, abort,
      input  cmd_ready, busy, done, err
   );

   // Sequencer side
   modport slave (
      input  cmd_valid, cmd_op, cmd_arg, abort,
      output cmd_ready, busy, done, err
   );

endinterface
`default_nettype wire

// File: rtl/counter_seq_ctrl_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : counter_seq_ctrl_timer                                      |
// | Loadable down-counter with zero / last-count flags. Holds a RUN_CYC  |
// | cycle count or the RUN_TO timeout budget.                            |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module counter_seq_ctrl_timer #(
   parameter int TW = 6
) (
   input  wire          clk,
   input  wire          asyn_rstn,
   input  wire          load,
   input  wire [TW-1:0] load_val,
   input  wire          dec,
   output logic         zero,
   output logic         last
);

   logic [TW-1:0] remain;

   // Load wins over decrement; decrement stops at zero so the flag is sticky
   always_ff @(posedge clk or negedge asyn_rstn) begin
      if (!asyn_rstn) begin
         remain <= '0;
      end else if (load) begin
         remain <= load_val;
      end else if (dec && (remain != '0)) begin
         remain <= remain - TW'(1);
      end
   end

   assign zero = (remain == '0);
   assign last = (remain == TW'(1));

endmodule
`default_nettype wire

// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : counter_seq_ctrl                                            |
// | Command sequencer for an up/down counter: accepts STOP / LOAD /      |
// | RUN_TO / RUN_CYC, drives the counter's enb/load/data_in and reports  |
// | completion (done) with an error flag for abort or timeout.           |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module counter_seq_ctrl
   import counter_seq_ctrl_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int TMO_CYC = tmo_cyc(WIDTH)
) (
   input  wire              clk,
   input  wire              asyn_rstn,
   counter_seq_ctrl_if.slave cmd,
   output logic             cnt_enb,
   output logic             cnt_load,
   output logic [WIDTH-1:0] cnt_data,
   input  wire  [WIDTH-1:0] cnt_count
);

   localparam int TW = tmr_width(TMO_CYC);

   state_e           state_q;
   state_e           state_d;
   op_e              op_q;
   logic [WIDTH-1:0] arg_q;
   logic             err_q;
   logic             err_d;

   logic             accept;
   logic             match;
   logic             tmr_load;
   logic [TW-1:0]    tmr_val;
   logic             tmr_zero;
   logic             tmr_last;

   assign accept = (state_q == S_IDLE) && cmd.cmd_valid;
   assign match  = (cnt_count == arg_q);

   // Cycle-count / timeout budget; consumed only on enabled counter cycles
   counter_seq_ctrl_timer #(
      .TW (TW)
   ) u_timer (
      .clk       (clk),
      .asyn_rstn (asyn_rstn),
      .load      (tmr_load),
      .load_val  (tmr_val),
      .dec       (cnt_enb),
      .zero      (tmr_zero),
      .last      (tmr_last)
   );

   // State, captured command fields and completion status
   always_ff @(posedge clk or negedge asyn_rstn) begin
      if (!asyn_rstn) begin
         state_q <= S_IDLE;
         op_q    <= OP_STOP;
         arg_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         if (accept) begin
            op_q  <= cmd.cmd_op;
            arg_q <= cmd.cmd_arg;
         end
      end
   end

   // Next-state and counter drive; everything towards the counter is a
   // function of registered state so cmd_* never reaches an output directly
   always_comb begin
      state_d  = state_q;
      err_d    = err_q;
      cnt_enb  = 1'b0;
      cnt_load = 1'b0;
      cnt_data = '0;
      tmr_load = 1'b0;
      tmr_val  = '0;

      case (state_q)
         S_IDLE: begin
            if (cmd.cmd_valid) begin
               err_d    = 1'b0;
               tmr_load = 1'b1;
               tmr_val  = (cmd.cmd_op == OP_RUN_TO) ? TW'(TMO_CYC) : TW'(cmd.cmd_arg);
               case (cmd.cmd_op)
                  OP_STOP:    state_d = S_DONE;
                  OP_LOAD:    state_d = S_LOAD;
                  OP_RUN_TO:  state_d = S_RUN;
                  OP_RUN_CYC: state_d = (cmd.cmd_arg == '0) ? S_DONE : S_RUN;
                  default:    state_d = S_DONE;
               endcase
            end
         end

         S_LOAD: begin
            cnt_load = 1'b1;
            cnt_data = arg_q;
            state_d  = S_DONE;
         end

         S_RUN: begin
            if (op_q == OP_RUN_TO) begin
               // Match beats abort beats timeout
               if (match) begin
                  state_d = S_DONE;
               end else if (cmd.abort || tmr_zero) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  cnt_enb = 1'b1;
               end
            end else begin
               // The final counted cycle completes even if abort arrives with it
               if (tmr_last) begin
                  cnt_enb = 1'b1;
                  state_d = S_DONE;
               end else if (cmd.abort) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  cnt_enb = 1'b1;
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign cmd.cmd_ready = (state_q == S_IDLE);
   assign cmd.busy      = (state_q != S_IDLE);
   assign cmd.done      = (state_q == S_DONE);
   assign cmd.err       = (state_q == S_DONE) && err_q;

endmodule
`default_nettype wire
